// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Shares the single bridge bus between two masters: M0 (CPU data port) and
//   M1 (secondary master, e.g. debug/DMA). One master is granted per
//   transaction. The winner's request is latched and driven onto the bridge
//   for a fixed access latency. The winner then gets a one-cycle done pulse,
//   and for reads it also gets registered read data.
//
//   Sequence: IDLE -> ACCESS (LAT cycles) -> DONE (1 cycle) -> IDLE
//
// Parameters
//   RD_LAT      read access cycles before Bus_rdata is valid (1..15)
//   WR_LAT      write access cycles (1..15)
//   PRIO_FIXED  0 = round-robin on ties, 1 = M0 always wins ties
//
// Ports
//   cpu_clk, cpu_rst         clock, synchronous active-high reset
//   m0_req/wen/addr/wdata    M0 request (held stable while req=1)
//   m0_done, m0_rdata        M0 completion pulse, M0 read data
//   m1_req/wen/addr/wdata    M1 request (held stable while req=1)
//   m1_done, m1_rdata        M1 completion pulse, M1 read data
//   Bus_addr/wen/wdata       bridge request outputs (registered)
//   Bus_rdata                bridge read data input
//   busy                     high whenever a transaction is in progress
//   owner                    index of the current or most recent grantee
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int WR_LAT     = 1,
  parameter int PRIO_FIXED = 0
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata,
  output logic        busy,
  output logic        owner
);

  // The 4-bit access counter limits both latencies to the range 1..15.
  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("bus_arbiter: RD_LAT must be in the range 1..15");
  end
  if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
    $error("bus_arbiter: WR_LAT must be in the range 1..15");
  end

  // Counter value reached on the final ACCESS cycle.
  localparam logic [3:0] RD_LAST = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t     state;
  logic       last;
  logic [3:0] cnt;
  logic [3:0] cnt_last;
  logic       wen_q;

  logic        any_req;
  logic        winner;
  logic        win_wen;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;

  // Tie-break. In round-robin mode the master that did not win last time
  // gets the grant. "last" resets to 1 so that M0 wins the first tie.
  always_comb begin
    any_req = m0_req | m1_req;
    winner  = 1'b0;
    if (m0_req && m1_req) begin
      winner = (PRIO_FIXED != 0) ? 1'b0 : ~last;
    end else if (m1_req) begin
      winner = 1'b1;
    end
    win_wen   = winner ? m1_wen   : m0_wen;
    win_addr  = winner ? m1_addr  : m0_addr;
    win_wdata = winner ? m1_wdata : m0_wdata;
  end

  assign busy = (state != IDLE);

  // Main sequencer.
  // The Bus_* registers also hold the latched address and write data for
  // the whole ACCESS phase. They are cleared on the edge into DONE, so the
  // bridge sees zeros in IDLE and in DONE.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= 4'd0;
      cnt_last  <= 4'd0;
      wen_q     <= 1'b0;
      owner     <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_rdata  <= 32'd0;
      m1_rdata  <= 32'd0;
      Bus_addr  <= 32'd0;
      Bus_wen   <= 1'b0;
      Bus_wdata <= 32'd0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            last      <= winner;
            cnt       <= 4'd0;
            cnt_last  <= win_wen ? WR_LAST : RD_LAST;
            wen_q     <= win_wen;
            Bus_addr  <= win_addr;
            Bus_wen   <= win_wen;
            Bus_wdata <= win_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // The write strobe is only a single-cycle pulse at the start of
          // the access.
          Bus_wen <= 1'b0;
          cnt     <= cnt + 4'd1;
          if (cnt == cnt_last) begin
            if (!wen_q) begin
              if (owner) begin
                m1_rdata <= Bus_rdata;
              end else begin
                m0_rdata <= Bus_rdata;
              end
            end
            m0_done   <= ~owner;
            m1_done   <= owner;
            Bus_addr  <= 32'd0;
            Bus_wdata <= 32'd0;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed bench for bus_arbiter. Both instances share the same inputs.
//   Each scenario starts from a reset, so the two instances stay in step.
//     dut_a : RD_LAT=2, WR_LAT=3, round-robin
//     dut_b : RD_LAT=3, WR_LAT=1, fixed priority
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;

  logic        a_m0_done, a_m1_done, a_bus_wen, a_busy, a_owner;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata;
  logic        b_m0_done, b_m1_done, b_bus_wen, b_busy, b_owner;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata;

  int tests    = 0;
  int failures = 0;

  always #5 cpu_clk = ~cpu_clk;

  bus_arbiter #(.RD_LAT(2), .WR_LAT(3), .PRIO_FIXED(0)) dut_a (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
    .Bus_addr(a_bus_addr), .Bus_wen(a_bus_wen), .Bus_wdata(a_bus_wdata),
    .Bus_rdata(bus_rdata), .busy(a_busy), .owner(a_owner)
  );

  bus_arbiter #(.RD_LAT(3), .WR_LAT(1), .PRIO_FIXED(1)) dut_b (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
    .Bus_addr(b_bus_addr), .Bus_wen(b_bus_wen), .Bus_wdata(b_bus_wdata),
    .Bus_rdata(bus_rdata), .busy(b_busy), .owner(b_owner)
  );

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // Two cycles of reset with every request input cleared.
  task automatic do_reset();
    cpu_rst  = 1'b1;
    m0_req   = 1'b0; m0_wen = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req   = 1'b0; m1_wen = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    bus_rdata = 32'd0;
    step();
    step();
    cpu_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if ({a_m0_done, a_m1_done, a_bus_wen, a_busy, a_owner} !== 5'd0) begin failures++; $display("[TB] FAIL reset_a_flags: got %b expected 00000", {a_m0_done, a_m1_done, a_bus_wen, a_busy, a_owner}); end
    tests++; if ({a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata} !== 128'd0) begin failures++; $display("[TB] FAIL reset_a_words: got %h expected 0", {a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata}); end
    tests++; if ({b_m0_done, b_m1_done, b_bus_wen, b_busy, b_owner} !== 5'd0) begin failures++; $display("[TB] FAIL reset_b_flags: got %b expected 00000", {b_m0_done, b_m1_done, b_bus_wen, b_busy, b_owner}); end
    tests++; if ({b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata} !== 128'd0) begin failures++; $display("[TB] FAIL reset_b_words: got %h expected 0", {b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata}); end
    step();
    tests++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", a_busy); end
  endtask

  // M0 read on dut_a (RD_LAT=2), requested in cycle T.
  task automatic test_read();
    do_reset();
    m0_wen = 1'b0; m0_addr = 32'h100; m0_wdata = 32'd0; bus_rdata = 32'hDEADBEEF;
    m0_req = 1'b1;
    step();
    tests++; if (a_bus_addr !== 32'h100) begin failures++; $display("[TB] FAIL read_addr_t1: got %h expected 00000100", a_bus_addr); end
    tests++; if ({a_bus_wen, a_busy, a_owner, a_m0_done} !== 4'b0100) begin failures++; $display("[TB] FAIL read_ctrl_t1: got %b expected 0100", {a_bus_wen, a_busy, a_owner, a_m0_done}); end
    step();
    tests++; if (a_bus_addr !== 32'h100) begin failures++; $display("[TB] FAIL read_addr_t2: got %h expected 00000100", a_bus_addr); end
    tests++; if (a_m0_done !== 1'b0) begin failures++; $display("[TB] FAIL read_early_done: got %b expected 0", a_m0_done); end
    step();
    tests++; if ({a_m0_done, a_m1_done} !== 2'b10) begin failures++; $display("[TB] FAIL read_done_t3: got %b expected 10", {a_m0_done, a_m1_done}); end
    tests++; if (a_m0_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL read_rdata: got %h expected deadbeef", a_m0_rdata); end
    tests++; if (a_bus_addr !== 32'd0) begin failures++; $display("[TB] FAIL read_bus_done: got %h expected 0", a_bus_addr); end
    m0_req = 1'b0;
    step();
    tests++; if ({a_m0_done, a_busy} !== 2'b00) begin failures++; $display("[TB] FAIL read_after: got %b expected 00", {a_m0_done, a_busy}); end
  endtask

  // M1 read that loads m1_rdata, then an M1 write on dut_a (WR_LAT=3).
  task automatic test_write();
    do_reset();
    m1_wen = 1'b0; m1_addr = 32'h204; bus_rdata = 32'hCAFEF00D;
    m1_req = 1'b1;
    step(); step(); step();
    tests++; if ({a_m1_done, a_m1_rdata} !== {1'b1, 32'hCAFEF00D}) begin failures++; $display("[TB] FAIL m1_read: got %b/%h expected 1/cafef00d", a_m1_done, a_m1_rdata); end
    m1_req = 1'b0;
    step();
    m1_wen = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h12345678; bus_rdata = 32'hBAD0BAD0;
    m1_req = 1'b1;
    step();
    tests++; if ({a_bus_wen, a_owner, a_bus_addr, a_bus_wdata} !== {1'b1, 1'b1, 32'h200, 32'h12345678}) begin failures++; $display("[TB] FAIL write_t1: got %b %b %h %h expected 1 1 00000200 12345678", a_bus_wen, a_owner, a_bus_addr, a_bus_wdata); end
    step();
    tests++; if ({a_bus_wen, a_bus_wdata} !== {1'b0, 32'h12345678}) begin failures++; $display("[TB] FAIL write_t2: got %b %h expected 0 12345678", a_bus_wen, a_bus_wdata); end
    step();
    tests++; if ({a_bus_wen, a_bus_wdata, a_m1_done} !== {1'b0, 32'h12345678, 1'b0}) begin failures++; $display("[TB] FAIL write_t3: got %b %h %b expected 0 12345678 0", a_bus_wen, a_bus_wdata, a_m1_done); end
    step();
    tests++; if ({a_m1_done, a_m0_done} !== 2'b10) begin failures++; $display("[TB] FAIL write_done_t4: got %b expected 10", {a_m1_done, a_m0_done}); end
    tests++; if (a_m1_rdata !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL write_keeps_rdata: got %h expected cafef00d", a_m1_rdata); end
    tests++; if (a_bus_wdata !== 32'd0) begin failures++; $display("[TB] FAIL write_bus_done: got %h expected 0", a_bus_wdata); end
    m1_req = 1'b0;
    step();
    tests++; if (a_m1_done !== 1'b0) begin failures++; $display("[TB] FAIL write_single_pulse: got %b expected 0", a_m1_done); end
  endtask

  // Both masters request continuously: dut_a alternates, dut_b always picks M0.
  task automatic test_round_robin();
    logic a_seq [4];
    logic b_seq [4];
    int   na = 0;
    int   nb = 0;
    do_reset();
    m0_addr = 32'hA0; m1_addr = 32'hB0; m0_wen = 1'b0; m1_wen = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if ((a_m0_done || a_m1_done) && na < 4) begin a_seq[na] = a_m1_done; na++; end
      if ((b_m0_done || b_m1_done) && nb < 4) begin b_seq[nb] = b_m1_done; nb++; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tests++; if (na !== 4 || nb !== 4) begin failures++; $display("[TB] FAIL arb_grant_count: got %0d/%0d expected 4/4", na, nb); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (i < na && a_seq[i] !== 1'(i % 2)) begin failures++; $display("[TB] FAIL rr_grant%0d: got M%0d expected M%0d", i, a_seq[i], i % 2); end
      tests++; if (i < nb && b_seq[i] !== 1'b0) begin failures++; $display("[TB] FAIL fixed_grant%0d: got M%0d expected M0", i, b_seq[i]); end
    end
  endtask

  // M1 requests during M0's ACCESS phase on dut_a.
  task automatic test_back_to_back();
    do_reset();
    m0_wen = 1'b0; m0_addr = 32'h300; bus_rdata = 32'h11112222;
    m0_req = 1'b1;
    step();
    m1_wen = 1'b0; m1_addr = 32'h400; m1_req = 1'b1;
    step();
    tests++; if ({a_bus_addr, a_owner} !== {32'h300, 1'b0}) begin failures++; $display("[TB] FAIL hold_t2: got %h %b expected 00000300 0", a_bus_addr, a_owner); end
    step();
    tests++; if ({a_m0_done, a_m1_done, a_m0_rdata} !== {2'b10, 32'h11112222}) begin failures++; $display("[TB] FAIL hold_m0_done: got %b%b %h expected 10 11112222", a_m0_done, a_m1_done, a_m0_rdata); end
    m0_req = 1'b0; bus_rdata = 32'h33334444;
    step();
    tests++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL hold_idle_gap: got %b expected 0", a_busy); end
    step();
    tests++; if ({a_bus_addr, a_owner} !== {32'h400, 1'b1}) begin failures++; $display("[TB] FAIL hold_m1_grant: got %h %b expected 00000400 1", a_bus_addr, a_owner); end
    step(); step();
    tests++; if ({a_m1_done, a_m1_rdata, a_m0_rdata} !== {1'b1, 32'h33334444, 32'h11112222}) begin failures++; $display("[TB] FAIL hold_m1_done: got %b %h %h expected 1 33334444 11112222", a_m1_done, a_m1_rdata, a_m0_rdata); end
    m1_req = 1'b0;
    step();
  endtask

  // Reset in the second ACCESS cycle of an RD_LAT=3 read on dut_b.
  task automatic test_reset_midflight();
    bit seen = 0;
    do_reset();
    m0_wen = 1'b0; m0_addr = 32'h500; m0_wdata = 32'hFFFF0000; bus_rdata = 32'h55AA55AA;
    m0_req = 1'b1;
    step(); step(); step(); step();
    tests++; if ({b_m0_done, b_m0_rdata} !== {1'b1, 32'h55AA55AA}) begin failures++; $display("[TB] FAIL rst_pre_read: got %b %h expected 1 55aa55aa", b_m0_done, b_m0_rdata); end
    m0_req = 1'b0;
    step();
    m0_addr = 32'h600; m0_req = 1'b1;
    step();
    tests++; if ({b_bus_addr, b_bus_wdata, b_busy} !== {32'h600, 32'hFFFF0000, 1'b1}) begin failures++; $display("[TB] FAIL rst_access1: got %h %h %b expected 00000600 ffff0000 1", b_bus_addr, b_bus_wdata, b_busy); end
    step();
    cpu_rst = 1'b1; m0_req = 1'b0;
    step();
    cpu_rst = 1'b0;
    tests++; if ({b_m0_done, b_bus_wen, b_busy, b_owner} !== 4'd0) begin failures++; $display("[TB] FAIL rst_flags: got %b expected 0000", {b_m0_done, b_bus_wen, b_busy, b_owner}); end
    tests++; if ({b_bus_addr, b_bus_wdata, b_m0_rdata} !== 96'd0) begin failures++; $display("[TB] FAIL rst_words: got %h expected 0", {b_bus_addr, b_bus_wdata, b_m0_rdata}); end
    step();
    tests++; if ({b_m0_done, b_busy} !== 2'b00) begin failures++; $display("[TB] FAIL rst_no_late_done: got %b expected 00", {b_m0_done, b_busy}); end
    bus_rdata = 32'h0BADF00D; m0_req = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (b_m0_done) seen = 1;
    end
    m0_req = 1'b0;
    tests++; if (!seen || b_m0_rdata !== 32'h0BADF00D) begin failures++; $display("[TB] FAIL rst_recover: got seen=%0d %h expected seen=1 0badf00d", seen, b_m0_rdata); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
